// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 2^AW words, WAIT data-phase wait states, byte-lane writes, read-after-write bypass.
// Optional macro AHB_SRAM_ERR_CHECK_EN adds size/alignment/range checking with a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int XLEN = 32,
  parameter int AW   = 12,
  parameter int WAIT = 0
) (
  input  logic            hclk,
  input  logic            hreset_n,
  input  logic            hsel,
  input  logic [XLEN-1:0] haddr,
  input  logic [1:0]      htrans,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic [3:0]      hprot,
  input  logic            hwrite,
  input  logic [XLEN-1:0] hwdata,
  input  logic            hready,
  output logic            hreadyout,
  output logic [XLEN-1:0] hrdata,
  output logic [1:0]      hresp,
  output logic [1:0]      dbg_state_o
);

  localparam int NB = XLEN / 8;
  localparam logic [2:0] CNT_INIT = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

`ifdef AHB_SRAM_ERR_CHECK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_e;
`endif

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            hreadyout_q;
  logic [XLEN-1:0] hrdata_q;
  logic            dp_valid_q;
  logic            dp_write_q;
  logic [AW-1:0]   dp_addr_q;
  logic [NB-1:0]   dp_be_q;

  logic [XLEN-1:0] mem [0:(1<<AW)-1];

  // Handshake: an address phase is accepted on an edge with hsel & htrans[1] & hready;
  // its data phase completes on the next edge where hready=1 while the FSM is back in IDLE.
  logic            accept;
  logic            wr_fire;
  logic [AW-1:0]   idx_a;
  logic [NB-1:0]   be_d;
  logic [XLEN-1:0] rd_word_d;

  assign accept  = hsel && htrans[1] && hready;
  assign wr_fire = (state_q == S_IDLE) && dp_valid_q && dp_write_q && hready;
  assign idx_a   = haddr[AW+1:2];

  always_comb begin
    be_d = '1;
    if (hsize == 3'd0)
      be_d = NB'(1) << haddr[1:0];
    else if (hsize == 3'd1)
      be_d = NB'(3) << {haddr[1], 1'b0};
  end

  // Zero-wait reads of the word being written this very edge take the fresh bytes.
  always_comb begin
    rd_word_d = mem[idx_a];
    if (wr_fire && (dp_addr_q == idx_a)) begin
      for (int i = 0; i < NB; i++)
        if (dp_be_q[i]) rd_word_d[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

`ifdef AHB_SRAM_ERR_CHECK_EN
  logic err_a;
  logic hresp_q;
  assign err_a = (hsize > 3'd2) || ((hsize == 3'd1) && haddr[0]) ||
                 ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) || (|haddr[XLEN-1:AW+2]);
  assign hresp = {1'b0, hresp_q};
`else
  assign hresp = 2'b00;
`endif

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_be_q     <= '0;
`ifdef AHB_SRAM_ERR_CHECK_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            if (!dp_write_q) hrdata_q <= mem[dp_addr_q];
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
`ifdef AHB_SRAM_ERR_CHECK_EN
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
        end
`endif
        default: begin
          if (hready) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            dp_valid_q  <= 1'b0;
`ifdef AHB_SRAM_ERR_CHECK_EN
            hresp_q     <= 1'b0;
`endif
            if (accept) begin
`ifdef AHB_SRAM_ERR_CHECK_EN
              if (err_a) begin
                state_q     <= S_ERR1;
                hreadyout_q <= 1'b0;
                hresp_q     <= 1'b1;
              end else
`endif
              begin
                dp_valid_q <= 1'b1;
                dp_write_q <= hwrite;
                dp_addr_q  <= idx_a;
                dp_be_q    <= be_d;
                if (WAIT > 0) begin
                  state_q     <= S_WAIT;
                  hreadyout_q <= 1'b0;
                  cnt_q       <= CNT_INIT;
                end else if (!hwrite) begin
                  hrdata_q <= rd_word_d;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // Memory has no reset; only enabled lanes are written on the completing edge.
  always_ff @(posedge hclk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++)
        if (dp_be_q[i]) mem[dp_addr_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, haddr};

  assign hreadyout   = hreadyout_q;
  assign hrdata      = hrdata_q;
  assign dbg_state_o = state_q;

endmodule
